// File: rtl/cpu_pkg.sv
// Shared definitions for the minimal 6502-compatible core: opcodes, T-states, flag positions.
package cpu_pkg;

  localparam logic [7:0] ADC_IMM = 8'h69;
  localparam logic [7:0] ADC_ABS = 8'h6D;
  localparam logic [7:0] SBC_IMM = 8'hE9;
  localparam logic [7:0] SEC     = 8'h38;
  localparam logic [7:0] CLC     = 8'h18;
  localparam logic [7:0] NOP     = 8'hEA;

  typedef enum logic [1:0] {
    StT0 = 2'd0,
    StT1 = 2'd1,
    StT2 = 2'd2,
    StT3 = 2'd3
  } t_state_e;

  // Bit positions inside the processor status register (6502 layout)
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 6;
  localparam int unsigned FLAG_N = 7;

endpackage

// File: rtl/cpu_if.sv
// Read-only memory bus between the core (master) and combinational memory (slave).
interface cpu_if;

  logic [15:0] Addr_bus;
  logic [7:0]  Data_bus;

  modport master (output Addr_bus, input Data_bus);
  modport slave  (input Addr_bus, output Data_bus);

endinterface

// File: rtl/cpu_alu.sv
// Binary add/subtract unit; subtraction is addition of the inverted operand plus carry.
module cpu_alu (
  input  logic [7:0] i_a,
  input  logic [7:0] i_m,
  input  logic       i_carry,
  input  logic       i_sub,
  output logic [7:0] o_result,
  output logic       o_c,
  output logic       o_z,
  output logic       o_n,
  output logic       o_v
);

  logic [7:0] w_m_eff;
  logic [8:0] w_sum;

  // Nine-bit sum and flag derivation
  always_comb begin
    w_m_eff  = i_sub ? ~i_m : i_m;
    w_sum    = {1'b0, i_a} + {1'b0, w_m_eff} + {8'd0, i_carry};
    o_result = w_sum[7:0];
    o_c      = w_sum[8];
    o_z      = (w_sum[7:0] == 8'd0);
    o_n      = w_sum[7];
    o_v      = (i_a[7] == w_m_eff[7]) && (w_sum[7] != i_a[7]);
  end

endmodule

// File: rtl/cpu.sv
// Minimal 6502-style core: sequencer, registers and bus address mux. ADC/SBC #imm, ADC abs,
// SEC, CLC; everything else is a two-cycle implied NOP.
module cpu
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic         clk_ph1,
  input  logic         rst,
  cpu_if.master        bus,
  output logic [7:0]   IR_dbg,
  output logic [7:0]   AC_dbg,
  output logic [15:0]  PC_dbg,
  output logic [2:0]   cycle_dbg
);

  t_state_e    r_t, w_t_next;
  logic [15:0] r_pc, w_pc_next;
  logic [7:0]  r_ac, w_ac_next;
  logic [7:0]  r_ir, w_ir_next;
  logic [7:0]  r_adl, w_adl_next;
  logic [7:0]  r_adh, w_adh_next;
  logic [7:0]  r_p, w_p_next;
  logic [7:0]  w_p_alu;
  logic [15:0] w_addr;

  logic [7:0]  w_alu_res;
  logic        w_alu_c, w_alu_z, w_alu_n, w_alu_v;
  logic        w_sub;

  assign w_sub = (r_ir == SBC_IMM);

  cpu_alu u_alu (
    .i_a      (r_ac),
    .i_m      (bus.Data_bus),
    .i_carry  (r_p[FLAG_C]),
    .i_sub    (w_sub),
    .o_result (w_alu_res),
    .o_c      (w_alu_c),
    .o_z      (w_alu_z),
    .o_n      (w_alu_n),
    .o_v      (w_alu_v)
  );

  // T-state register
  always_ff @(posedge clk_ph1) begin
    if (rst) begin
      r_t <= StT0;
    end else begin
      r_t <= w_t_next;
    end
  end

  // T-state sequencing: only ADC abs runs past T1
  always_comb begin
    w_t_next = StT0;
    unique case (r_t)
      StT0:    w_t_next = StT1;
      StT1:    w_t_next = (r_ir == ADC_ABS) ? StT2 : StT0;
      StT2:    w_t_next = StT3;
      StT3:    w_t_next = StT0;
      default: w_t_next = StT0;
    endcase
  end

  // Status register image after an ADC/SBC
  always_comb begin
    w_p_alu         = r_p;
    w_p_alu[FLAG_C] = w_alu_c;
    w_p_alu[FLAG_Z] = w_alu_z;
    w_p_alu[FLAG_N] = w_alu_n;
    w_p_alu[FLAG_V] = w_alu_v;
  end

  // Per-T-state bus address and register next values
  always_comb begin
    w_addr     = r_pc;
    w_pc_next  = r_pc;
    w_ac_next  = r_ac;
    w_ir_next  = r_ir;
    w_adl_next = r_adl;
    w_adh_next = r_adh;
    w_p_next   = r_p;
    unique case (r_t)
      StT0: begin
        w_ir_next = bus.Data_bus;
        w_pc_next = r_pc + 16'd1;
      end
      StT1: begin
        case (r_ir)
          ADC_IMM, SBC_IMM: begin
            w_ac_next = w_alu_res;
            w_p_next  = w_p_alu;
            w_pc_next = r_pc + 16'd1;
          end
          ADC_ABS: begin
            w_adl_next = bus.Data_bus;
            w_pc_next  = r_pc + 16'd1;
          end
          SEC:     w_p_next[FLAG_C] = 1'b1;
          CLC:     w_p_next[FLAG_C] = 1'b0;
          NOP:     ;
          default: ;
        endcase
      end
      StT2: begin
        w_adh_next = bus.Data_bus;
        w_pc_next  = r_pc + 16'd1;
      end
      StT3: begin
        w_addr    = {r_adh, r_adl};
        w_ac_next = w_alu_res;
        w_p_next  = w_p_alu;
      end
      default: ;
    endcase
  end

  // Architectural registers; reset discards any in-flight update
  always_ff @(posedge clk_ph1) begin
    if (rst) begin
      r_pc  <= RESET_PC;
      r_ac  <= 8'd0;
      r_ir  <= 8'd0;
      r_adl <= 8'd0;
      r_adh <= 8'd0;
      r_p   <= 8'd0;
    end else begin
      r_pc  <= w_pc_next;
      r_ac  <= w_ac_next;
      r_ir  <= w_ir_next;
      r_adl <= w_adl_next;
      r_adh <= w_adh_next;
      r_p   <= w_p_next;
    end
  end

  assign bus.Addr_bus = rst ? RESET_PC : w_addr;
  assign IR_dbg       = r_ir;
  assign AC_dbg       = r_ac;
  assign PC_dbg       = r_pc;
  assign cycle_dbg    = {1'b0, r_t};

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: directed programs plus random programs checked against an
// instruction-level reference interpreter.
module tb_cpu;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  logic [7:0] mem [0:65535];

  cpu_if bus ();
  cpu_if bus2 ();
  assign bus.Data_bus  = mem[bus.Addr_bus];
  assign bus2.Data_bus = mem[bus2.Addr_bus];

  logic [7:0]  ir, ac, ir2, ac2;
  logic [15:0] pc, pc2;
  logic [2:0]  cyc, cyc2;

  cpu #(.RESET_PC(16'h0000)) dut (
    .clk_ph1(clk), .rst(rst), .bus(bus),
    .IR_dbg(ir), .AC_dbg(ac), .PC_dbg(pc), .cycle_dbg(cyc)
  );

  // Second core starts near the top of memory to exercise PC wrap
  cpu #(.RESET_PC(16'hFFFE)) dut2 (
    .clk_ph1(clk), .rst(rst2), .bus(bus2),
    .IR_dbg(ir2), .AC_dbg(ac2), .PC_dbg(pc2), .cycle_dbg(cyc2)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model: architectural state advanced one whole instruction at a time
  logic [7:0]  m_a;
  logic [15:0] m_pc;
  logic        m_c, m_z, m_n, m_v;

  task automatic model_reset();
    m_a = 8'd0; m_pc = 16'd0;
    m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
  endtask

  task automatic model_add(input logic [7:0] m);
    int s;
    logic [7:0] r;
    s = int'(m_a) + int'(m) + int'(m_c);
    r = 8'(s);
    m_v = ((m_a ^ r) & (m ^ r) & 8'h80) != 8'h00;
    m_c = s > 255;
    m_z = r == 8'h00;
    m_n = r >= 8'h80;
    m_a = r;
  endtask

  task automatic model_step(output int cycles, output logic [7:0] op);
    logic [15:0] ea;
    op = mem[m_pc];
    case (op)
      8'h69: begin model_add(mem[m_pc + 16'd1]);  m_pc = m_pc + 16'd2; cycles = 2; end
      8'hE9: begin model_add(~mem[m_pc + 16'd1]); m_pc = m_pc + 16'd2; cycles = 2; end
      8'h6D: begin
        ea = {mem[m_pc + 16'd2], mem[m_pc + 16'd1]};
        model_add(mem[ea]);
        m_pc = m_pc + 16'd3;
        cycles = 4;
      end
      8'h38:   begin m_c = 1'b1; m_pc = m_pc + 16'd1; cycles = 2; end
      8'h18:   begin m_c = 1'b0; m_pc = m_pc + 16'd1; cycles = 2; end
      default: begin m_pc = m_pc + 16'd1; cycles = 2; end
    endcase
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "/A"},   {24'd0, ac},  {24'd0, m_a});
    check({tag, "/PC"},  {16'd0, pc},  {16'd0, m_pc});
    check({tag, "/T"},   {29'd0, cyc}, 32'd0);
    check({tag, "/C"},   {31'd0, dut.r_p[FLAG_C]}, {31'd0, m_c});
    check({tag, "/Z"},   {31'd0, dut.r_p[FLAG_Z]}, {31'd0, m_z});
    check({tag, "/N"},   {31'd0, dut.r_p[FLAG_N]}, {31'd0, m_n});
    check({tag, "/V"},   {31'd0, dut.r_p[FLAG_V]}, {31'd0, m_v});
  endtask

  task automatic run_instr(input string tag);
    int n;
    logic [7:0] op;
    model_step(n, op);
    edges(n);
    check_state(tag);
    check({tag, "/IR"}, {24'd0, ir}, {24'd0, op});
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  task automatic restart();
    rst = 1'b1;
    edges(1);
    rst = 1'b0;
    model_reset();
  endtask

  int addr_hits = 0;
  logic watch = 1'b0;

  // Count cycles in which the aborted instruction's operand address reaches the bus
  always @(posedge clk) if (watch && bus.Addr_bus == 16'h1234) addr_hits++;

  initial begin
    clear_mem();
    mem[16'hFFFE] = 8'h69;
    mem[16'hFFFF] = 8'h22;

    // Reset state
    edges(2);
    check("rst/Addr", {16'd0, bus.Addr_bus}, 32'h0);
    check("rst/PC",   {16'd0, pc}, 32'h0);
    check("rst/AC",   {24'd0, ac}, 32'h0);
    check("rst/T",    {29'd0, cyc}, 32'h0);
    check("rst/IR",   {24'd0, ir}, 32'h0);
    check("rst2/Addr", {16'd0, bus2.Addr_bus}, 32'hFFFE);

    // PC wrap on the second core: ADC #$22 straddling FFFF->0000
    rst2 = 1'b0;
    edges(2);
    check("wrap/PC", {16'd0, pc2}, 32'h0000);
    check("wrap/A",  {24'd0, ac2}, 32'h22);
    rst2 = 1'b1;

    // Reference program from the block description
    mem[0] = 8'h69; mem[1] = 8'h04; mem[2] = 8'h6D; mem[3] = 8'h08; mem[4] = 8'h00;
    mem[5] = 8'h38; mem[6] = 8'hE9; mem[7] = 8'h09; mem[8] = 8'h05;
    rst = 1'b0;
    edges(2);
    check("prog2/A",  {24'd0, ac}, 32'h04);
    check("prog2/PC", {16'd0, pc}, 32'h0002);
    edges(3);
    check("prog5/T",    {29'd0, cyc}, 32'd3);
    check("prog5/Addr", {16'd0, bus.Addr_bus}, 32'h0008);
    edges(1);
    check("prog6/A",  {24'd0, ac}, 32'h09);
    check("prog6/PC", {16'd0, pc}, 32'h0005);
    edges(2);
    check("prog8/C", {31'd0, dut.r_p[FLAG_C]}, 32'd1);
    edges(2);
    check("prog10/A",  {24'd0, ac}, 32'h00);
    check("prog10/PC", {16'd0, pc}, 32'h0008);
    check("prog10/C",  {31'd0, dut.r_p[FLAG_C]}, 32'd1);
    check("prog10/Z",  {31'd0, dut.r_p[FLAG_Z]}, 32'd1);
    edges(2);
    check("unk/PC", {16'd0, pc}, 32'h0009);
    check("unk/A",  {24'd0, ac}, 32'h00);
    check("unk/T",  {29'd0, cyc}, 32'd0);
    check("unk/IR", {24'd0, ir}, 32'h05);
    check("unk/C",  {31'd0, dut.r_p[FLAG_C]}, 32'd1);
    check("unk/Z",  {31'd0, dut.r_p[FLAG_Z]}, 32'd1);

    // Carry / overflow / borrow
    clear_mem();
    mem[0] = 8'h69; mem[1] = 8'h7F; mem[2] = 8'h69; mem[3] = 8'h01;
    mem[4] = 8'h69; mem[5] = 8'h80; mem[6] = 8'h18; mem[7] = 8'hE9; mem[8] = 8'h00;
    restart();
    run_instr("cv/adc7f");
    run_instr("cv/adc01");
    check("cv1/A", {24'd0, ac}, 32'h80);
    check("cv1/V", {31'd0, dut.r_p[FLAG_V]}, 32'd1);
    check("cv1/N", {31'd0, dut.r_p[FLAG_N]}, 32'd1);
    check("cv1/C", {31'd0, dut.r_p[FLAG_C]}, 32'd0);
    run_instr("cv/adc80");
    check("cv2/A", {24'd0, ac}, 32'h00);
    check("cv2/C", {31'd0, dut.r_p[FLAG_C]}, 32'd1);
    check("cv2/Z", {31'd0, dut.r_p[FLAG_Z]}, 32'd1);
    check("cv2/V", {31'd0, dut.r_p[FLAG_V]}, 32'd1);
    run_instr("cv/clc");
    run_instr("cv/sbc00");
    check("sbc/A", {24'd0, ac}, 32'hFF);
    check("sbc/C", {31'd0, dut.r_p[FLAG_C]}, 32'd0);
    check("sbc/N", {31'd0, dut.r_p[FLAG_N]}, 32'd1);

    // Reset during T2 of ADC abs
    clear_mem();
    mem[0] = 8'h69; mem[1] = 8'h11; mem[2] = 8'h6D; mem[3] = 8'h34; mem[4] = 8'h12;
    mem[16'h1234] = 8'h55;
    restart();
    run_instr("abort/adc");
    edges(2);
    check("abort/T2", {29'd0, cyc}, 32'd2);
    watch = 1'b1;
    rst = 1'b1;
    edges(1);
    watch = 1'b0;
    check("abort/PC",   {16'd0, pc}, 32'h0);
    check("abort/T",    {29'd0, cyc}, 32'd0);
    check("abort/A",    {24'd0, ac}, 32'h0);
    check("abort/hits", addr_hits, 32'd0);

    // Random programs against the reference interpreter
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    begin
      logic [15:0] wp;
      wp = 16'd0;
      for (int k = 0; k < 300; k++) begin
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
          0, 1, 2: begin mem[wp] = 8'h69; wp = wp + 16'd2; end
          3, 4:    begin mem[wp] = 8'hE9; wp = wp + 16'd2; end
          5, 6:    begin mem[wp] = 8'h6D; wp = wp + 16'd3; end
          7:       begin mem[wp] = 8'h38; wp = wp + 16'd1; end
          8:       begin mem[wp] = 8'h18; wp = wp + 16'd1; end
          default: begin mem[wp] = 8'($urandom); wp = wp + 16'd1; end
        endcase
      end
    end
    restart();
    for (int k = 0; k < 300; k++) run_instr($sformatf("rnd%0d", k));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu.md
Name: cpu

Overview:
- Minimal 6502-compatible CPU core for the NES FPGA design; the supported subset is ADC/SBC immediate, ADC absolute, SEC, CLC and an implied NOP.
- Read-only external bus: the core drives a 16-bit address every cycle and samples the 8-bit data bus on the next rising clock edge. The memory behind the bus is combinational: data is valid in the same cycle as the address.
- Debug ports expose IR, accumulator, PC and the T-state for bench observation.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset (no vector fetch).

Ports:
- clk_ph1  input  1  sole clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- Data_bus  input  8  read data for the current Addr_bus.
- Addr_bus  output  16  bus address; combinational from state.
- IR_dbg  output  8  instruction register.
- AC_dbg  output  8  accumulator.
- PC_dbg  output  16  program counter.
- cycle_dbg  output  3  current T-state (0..3).

Behaviour:
- Interface: one clock (clk_ph1); reset (rst) is synchronous and active-high. There is no clk_ph2 port.
- Reset (rst=1 at an edge) sets PC=RESET_PC, A=0, IR=0, T=0, C=Z=N=V=0, and clears the address latches ADL and ADH.
- While in reset, Addr_bus=PC=0.
- T0, all opcodes:
  - Addr_bus=PC; at the edge IR<=Data_bus, PC<=PC+1, T<=1.
  - IR_dbg shows the new opcode from T1 onward.
- ADC #imm (0x69), 2 cycles:
  - T1: Addr_bus=PC; at the edge A<=A+M+C, PC+1, T<=0.
- SBC #imm (0xE9), 2 cycles:
  - T1 as for ADC, with A<=A+~M+C.
- ADC abs (0x6D), 4 cycles:
  - T1: Addr=PC; ADL<=data, PC+1.
  - T2: Addr=PC; ADH<=data, PC+1.
  - T3: Addr={ADH,ADL}; A<=A+M+C, T<=0. PC does not change in T3.
- SEC (0x38) / CLC (0x18), 2 cycles:
  - T1: Addr=PC (dummy read, PC not incremented); C<=1 / C<=0; T<=0.
- Any other opcode: 2-cycle implied NOP. T1 is a dummy read at PC; no state changes except T.
- Arithmetic, binary only (decimal flag ignored):
  - 9-bit sum; C = bit 8 of the sum.
  - Z = (result==0); N = result[7].
  - V = (A[7]==M'[7]) && (result[7]!=A[7]), where M' is M for ADC and ~M for SBC.
- Flags change only on ADC/SBC (C, Z, N, V) and on SEC/CLC (C only).
- PC wraps from 16'hFFFF to 16'h0000. The ADH:ADL address wraps naturally.
- Reset asserted mid-instruction aborts it immediately; no partial register write occurs at that edge.
- cycle_dbg = T. T never exceeds 3.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams: ADC_IMM=8'h69, ADC_ABS=8'h6D, SBC_IMM=8'hE9, SEC=8'h38, CLC=8'h18, NOP=8'hEA;
  - the T-state encoding;
  - the flag bit positions.
- One natural sub-module, cpu_alu: combinational; inputs A, M, carry-in, subtract; outputs result, C, Z, N, V.
- The sequencer, registers and bus mux stay in cpu.

Test Plan:
- Reset: hold rst=1 for 2 edges -> Addr_bus=0, PC_dbg=0, AC_dbg=0, cycle_dbg=0, IR_dbg=0.
- Program mem[0..8] = 69 04 6D 08 00 38 E9 09 05, 0 elsewhere; release reset. Required state:
  - after 2 edges: A=4, PC=2;
  - after 6 edges: A=9 (absolute read at Addr_bus=0x0008 seen in T3), PC=5;
  - after 8 edges: C=1;
  - after 10 edges: A=0, PC=8, C=1, Z=1.
- Carry/overflow: A=0x7F via ADC #0x7F, then ADC #0x01 with C=0 -> A=0x80, V=1, N=1, C=0. Then ADC #0x80 -> A=0x00, C=1, Z=1, V=1.
- SBC borrow: CLC; SBC #0x00 from A=0x00 -> A=0xFF, C=0, N=1.
- Unknown opcode 0x05 at PC=8 -> 2 cycles; only PC changes (to 9); A and flags unchanged.
- Reset mid-ADC-abs (rst=1 during T2) -> next cycle PC=0, T=0, A=0; no operand fetch at the absolute address.
